// File: rtl/dbg_scan_ctrl.sv
// Debug-view scan sequencer: on each display tick, fetches the next entry of the
// selected debug source over a req/ack read port and holds it for the 7-seg path.
module dbg_scan_ctrl #(
  parameter int RF_DEPTH  = 32,
  parameter int DM_DEPTH  = 8,
  parameter int ALU_DEPTH = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tick_i,
  input  logic [1:0]  src_sel_i,
  output logic        rd_req_o,
  output logic [1:0]  rd_src_o,
  output logic [5:0]  rd_addr_o,
  input  logic        rd_ack_i,
  input  logic [31:0] rd_data_i,
  output logic [31:0] disp_data_o,
  output logic [5:0]  disp_addr_o,
  output logic        disp_valid_o,
  output logic        busy_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [5:0]    scan_q;
  logic [5:0]    last_addr;
  logic [1:0]    src_q;
  logic          pending_q;
  logic [CW-1:0] cnt_q;

  logic src_chg, start, abort, ack_done, tmo, finish;

  // A changed select (including 00) always beats an ack or a timeout in the same cycle.
  assign src_chg  = (src_sel_i != src_q);
  assign start    = (state_q == IDLE) && (tick_i || pending_q) && (src_sel_i != 2'b00);
  assign abort    = (state_q == REQ) && src_chg;
  assign ack_done = (state_q == REQ) && !src_chg && rd_ack_i;
  assign tmo      = (state_q == REQ) && !src_chg && !rd_ack_i && (cnt_q == CW'(TIMEOUT - 1));
  assign finish   = ack_done || tmo;

  assign rd_src_o  = src_q;
  assign rd_addr_o = scan_q;

  always_comb begin
    case (src_q)
      2'b01:   last_addr = 6'(RF_DEPTH - 1);
      2'b10:   last_addr = 6'(DM_DEPTH - 1);
      2'b11:   last_addr = 6'(ALU_DEPTH - 1);
      default: last_addr = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement or process order.
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first so no path through the block leaves
    // state_d unassigned, which would infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ:     if (abort || finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request outputs decode straight from the state flop, so reset drops them at once.
  always_comb begin
    rd_req_o = 1'b0;
    busy_o   = 1'b0;
    if (state_q == REQ) begin
      rd_req_o = 1'b1;
      busy_o   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scan_q       <= '0;
      src_q        <= 2'b00;
      pending_q    <= 1'b0;
      cnt_q        <= '0;
      disp_data_o  <= '0;
      disp_addr_o  <= '0;
      disp_valid_o <= 1'b0;
    end else begin
      if (start) src_q <= src_sel_i;

      // Only one tick is remembered; it is consumed (or dropped) in the next IDLE cycle.
      pending_q <= (state_q == REQ) && !abort && (pending_q || tick_i);
      cnt_q     <= (state_q == REQ) ? cnt_q + CW'(1) : '0;

      if (src_chg)     scan_q <= '0;
      else if (finish) scan_q <= (scan_q == last_addr) ? 6'd0 : scan_q + 6'd1;

      if (finish) begin
        disp_data_o <= ack_done ? rd_data_i : 32'hFFFF_FFFF;
        disp_addr_o <= scan_q;
      end

      if (src_chg)     disp_valid_o <= 1'b0;
      else if (finish) disp_valid_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dbg_scan_ctrl.sv
// Self-checking bench for dbg_scan_ctrl: directed scenarios with literal expectations
// plus a transaction-level reference model compared on every falling clock edge.
module tb_dbg_scan_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        tick_i = 1'b0;
  logic [1:0]  src_sel_i = 2'b00;
  logic        rd_req_o;
  logic [1:0]  rd_src_o;
  logic [5:0]  rd_addr_o;
  logic        rd_ack_i;
  logic [31:0] rd_data_i;
  logic [31:0] disp_data_o;
  logic [5:0]  disp_addr_o;
  logic        disp_valid_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Responder controls: ack_lat = REQ cycle (1-based) in which to ack, 0 = never.
  int          ack_lat   = 1;
  bit          force_ack = 1'b0;
  logic [31:0] data_base = 32'h100;
  int          age       = 0;

  dbg_scan_ctrl #(
    .RF_DEPTH(32), .DM_DEPTH(8), .ALU_DEPTH(4), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rstn(rstn), .tick_i(tick_i), .src_sel_i(src_sel_i),
    .rd_req_o(rd_req_o), .rd_src_o(rd_src_o), .rd_addr_o(rd_addr_o),
    .rd_ack_i(rd_ack_i), .rd_data_i(rd_data_i),
    .disp_data_o(disp_data_o), .disp_addr_o(disp_addr_o),
    .disp_valid_o(disp_valid_o), .busy_o(busy_o)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Read-port responder: acks on a chosen REQ cycle, data derived from the address.
  initial begin
    rd_ack_i  = 1'b0;
    rd_data_i = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rd_req_o) age++;
      else          age = 0;
      rd_ack_i  = force_ack || (ack_lat > 0 && rd_req_o && age == ack_lat);
      rd_data_i = force_ack ? 32'hDEAD_BEEF : data_base + 32'(rd_addr_o);
    end
  end

  // Reference model: one fetch in flight at a time, addresses wrap modulo source depth.
  bit          m_busy, m_pend, m_dv;
  int          m_addr, m_wait, m_da;
  logic [1:0]  m_src;
  logic [31:0] m_dd;

  function automatic int depth_of(input logic [1:0] s);
    case (s)
      2'b01:   return 32;
      2'b10:   return 8;
      2'b11:   return 4;
      default: return 1;
    endcase
  endfunction

  task automatic model_complete(input logic [31:0] v);
    m_dd   = v;
    m_da   = m_addr;
    m_dv   = 1'b1;
    m_addr = (m_addr + 1) % depth_of(m_src);
    m_busy = 1'b0;
  endtask

  task automatic model_step();
    if (!m_busy) begin
      if (src_sel_i != m_src) begin
        m_addr = 0;
        m_dv   = 1'b0;
      end
      if (src_sel_i != 2'b00 && (tick_i || m_pend)) begin
        m_busy = 1'b1;
        m_src  = src_sel_i;
        m_wait = 0;
      end
      m_pend = 1'b0;
    end else if (src_sel_i != m_src) begin
      m_busy = 1'b0;
      m_addr = 0;
      m_pend = 1'b0;
      m_dv   = 1'b0;
    end else begin
      if (tick_i) m_pend = 1'b1;
      if (rd_ack_i) model_complete(rd_data_i);
      else begin
        m_wait++;
        if (m_wait == TIMEOUT) model_complete(32'hFFFF_FFFF);
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      m_busy = 1'b0; m_pend = 1'b0; m_dv = 1'b0;
      m_addr = 0; m_wait = 0; m_da = 0;
      m_src  = 2'b00; m_dd = '0;
    end else begin
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (rstn) begin
      check("m_rd_req", 32'(rd_req_o), 32'(m_busy));
      check("m_busy", 32'(busy_o), 32'(m_busy));
      check("m_disp_data", disp_data_o, m_dd);
      check("m_disp_addr", 32'(disp_addr_o), 32'(m_da));
      check("m_disp_valid", 32'(disp_valid_o), 32'(m_dv));
      if (m_busy) begin
        check("m_rd_src", 32'(rd_src_o), 32'(m_src));
        check("m_rd_addr", 32'(rd_addr_o), 32'(m_addr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse();
    tick_i = 1'b1;
    cyc(1);
    tick_i = 1'b0;
  endtask

  int busy_cnt;
  int req_cnt;
  int starts;
  bit req_hist [0:24];

  initial begin
    #2 rstn = 1'b0;
    #10;
    check("rst_req", 32'(rd_req_o), 0);
    check("rst_valid", 32'(disp_valid_o), 0);
    check("rst_data", disp_data_o, 0);
    #10 rstn = 1'b1;
    cyc(1);
    @(negedge clk);
    check("post_rst_busy", 32'(busy_o), 0);
    check("post_rst_addr", 32'(rd_addr_o), 0);
    cyc(1);

    // RF sweep, ack in first REQ cycle, ticks 10 cycles apart
    src_sel_i = 2'b01;
    data_base = 32'h100;
    ack_lat   = 1;
    cyc(2);
    for (int i = 0; i < 33; i++) begin
      pulse();
      @(negedge clk);
      check("rf_req", 32'(rd_req_o), 1);
      check("rf_addr", 32'(rd_addr_o), 32'(i % 32));
      cyc(1);
      @(negedge clk);
      check("rf_data", disp_data_o, 32'h100 + 32'(i % 32));
      check("rf_valid", 32'(disp_valid_o), 1);
      cyc(8);
    end

    // DM wrap, ack 3 cycles after request
    src_sel_i = 2'b10;
    data_base = 32'h200;
    ack_lat   = 4;
    cyc(1);
    @(negedge clk);
    check("dm_switch_valid", 32'(disp_valid_o), 0);
    cyc(1);
    for (int i = 0; i < 9; i++) begin
      pulse();
      @(negedge clk);
      check("dm_addr", 32'(rd_addr_o), 32'(i % 8));
      check("dm_src", 32'(rd_src_o), 32'h2);
      busy_cnt = int'(busy_o);
      for (int k = 0; k < 7; k++) begin
        cyc(1);
        @(negedge clk);
        busy_cnt += int'(busy_o);
      end
      check("dm_busy_cycles", 32'(busy_cnt), 4);
      check("dm_data", disp_data_o, 32'h200 + 32'(i % 8));
      cyc(1);
    end

    // Timeout on ALU source, then a late ack
    src_sel_i = 2'b11;
    ack_lat   = 0;
    cyc(1);
    pulse();
    req_cnt = 0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      req_cnt += int'(rd_req_o);
      cyc(1);
    end
    check("tmo_req_cycles", 32'(req_cnt), 15);
    check("tmo_data", disp_data_o, 32'hFFFF_FFFF);
    check("tmo_addr", 32'(disp_addr_o), 0);
    check("tmo_valid", 32'(disp_valid_o), 1);
    force_ack = 1'b1;
    cyc(1);
    force_ack = 1'b0;
    @(negedge clk);
    check("late_ack_data", disp_data_o, 32'hFFFF_FFFF);
    check("late_ack_valid", 32'(disp_valid_o), 1);
    check("late_ack_req", 32'(rd_req_o), 0);
    cyc(2);

    // Pending ticks: three during a slow REQ, one coinciding with an ack
    ack_lat   = 6;
    data_base = 32'h300;
    pulse();
    req_hist[0] = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      tick_i = (c == 2 || c == 3 || c == 5 || c == 13);
      @(negedge clk);
      req_hist[c] = rd_req_o;
      if (c == 8)  check("pend_addr2", 32'(rd_addr_o), 2);
      if (c == 15) check("pend_addr3", 32'(rd_addr_o), 3);
      cyc(1);
    end
    tick_i = 1'b0;
    starts = 0;
    for (int c = 1; c <= 24; c++)
      if (req_hist[c] && !req_hist[c-1]) starts++;
    check("pend_starts", 32'(starts), 3);
    check("pend_gap_idle", 32'(req_hist[7]), 0);
    check("pend_restart", 32'(req_hist[8]), 1);
    check("tick_ack_idle", 32'(req_hist[14]), 0);
    check("tick_ack_restart", 32'(req_hist[15]), 1);
    check("pend_last_data", disp_data_o, 32'h303);

    // Source switch mid-fetch: RF addr 5 aborted by DM select
    src_sel_i = 2'b01;
    data_base = 32'h100;
    ack_lat   = 1;
    cyc(1);
    repeat (5) begin
      pulse();
      cyc(3);
    end
    ack_lat = 8;
    pulse();
    @(negedge clk);
    check("sw_req", 32'(rd_req_o), 1);
    check("sw_addr5", 32'(rd_addr_o), 5);
    check("sw_src_rf", 32'(rd_src_o), 32'h1);
    cyc(1);
    src_sel_i = 2'b10;
    cyc(1);
    @(negedge clk);
    check("sw_req_drop", 32'(rd_req_o), 0);
    check("sw_valid", 32'(disp_valid_o), 0);
    ack_lat = 2;
    cyc(1);
    pulse();
    @(negedge clk);
    check("sw_dm_src", 32'(rd_src_o), 32'h2);
    check("sw_dm_addr", 32'(rd_addr_o), 0);
    cyc(4);

    // Asynchronous reset in the middle of a REQ
    ack_lat = 0;
    pulse();
    @(negedge clk);
    check("ar_pre_req", 32'(rd_req_o), 1);
    #2 rstn = 1'b0;
    #1;
    check("ar_req", 32'(rd_req_o), 0);
    check("ar_busy", 32'(busy_o), 0);
    check("ar_src", 32'(rd_src_o), 0);
    check("ar_addr", 32'(rd_addr_o), 0);
    check("ar_data", disp_data_o, 0);
    check("ar_daddr", 32'(disp_addr_o), 0);
    check("ar_valid", 32'(disp_valid_o), 0);
    @(negedge clk);
    rstn = 1'b1;
    cyc(1);
    ack_lat   = 1;
    data_base = 32'h200;
    pulse();
    @(negedge clk);
    check("ar_fetch_req", 32'(rd_req_o), 1);
    check("ar_fetch_addr", 32'(rd_addr_o), 0);
    cyc(1);
    @(negedge clk);
    check("ar_fetch_data", disp_data_o, 32'h200);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dbg_scan_ctrl.md
Name: dbg_scan_ctrl

Overview:
- Debug-view scheduler for the single-cycle RISC-V board design.
- On each display tick, it walks the selected debug source (register file, data memory, or ALU fields) one entry at a time.
- It fetches each entry over a shared request/acknowledge read port and holds the result for the 7-segment display path.
- It replaces free-running per-source counters with one arbitrated, handshaked sequencer.

Parameters:
- RF_DEPTH, 32: register-file entries scanned (addr 0..RF_DEPTH-1).
- DM_DEPTH, 8: data-memory words scanned (addr 0..DM_DEPTH-1).
- ALU_DEPTH, 4: ALU fields scanned (0=A, 1=B, 2=C, 3=Zero).
- TIMEOUT, 15: max cycles waiting for rd_ack_i before abort.

Ports:
- clk  in  1  system clock; the only clock.
- rstn  in  1  asynchronous active-low reset.
- tick_i  in  1  one-cycle advance pulse from the display-rate divider.
- src_sel_i  in  2  source select: 00 off, 01 RF, 10 DM, 11 ALU.
- rd_req_o  out  1  read request to the source mux.
- rd_src_o  out  2  source of the current request (copy of the latched select).
- rd_addr_o  out  6  entry address of the current request.
- rd_ack_i  in  1  read acknowledge; rd_data_i is valid in the same cycle.
- rd_data_i  in  32  read data.
- disp_data_o  out  32  last fetched value, or 32'hFFFFFFFF marker.
- disp_addr_o  out  6  address of the value on disp_data_o.
- disp_valid_o  out  1  disp_data_o holds a completed fetch.
- busy_o  out  1  high in REQ state.

Behaviour:
- Reset (async, rstn=0), all registers cleared:
  - state=IDLE, scan addr=0, latched src=00, pending=0, timeout cnt=0.
  - rd_req_o=0, rd_src_o=0, rd_addr_o=0.
  - disp_data_o=32'h0, disp_addr_o=0, disp_valid_o=0, busy_o=0.
- Reset mid-fetch: rd_req_o drops immediately (asynchronously); no partial update survives.
- Depth for the current source: RF_DEPTH, DM_DEPTH, or ALU_DEPTH.
- IDLE state:
  - If tick_i or pending is 1, and src_sel_i != 00, go to REQ next cycle.
  - On that entry: latch src_sel_i into rd_src_o, drive rd_addr_o = scan addr, clear pending.
  - With src_sel_i == 00: ticks are ignored and pending is cleared.
- REQ state:
  - rd_req_o=1 and busy_o=1.
  - rd_src_o and rd_addr_o are held stable until ack or abort.
- Ack in REQ (rd_ack_i=1):
  - Same cycle: rd_data_i is captured into disp_data_o, rd_addr_o into disp_addr_o.
  - Next cycle: disp_valid_o=1, scan addr advances, state=IDLE.
  - Fetch latency: request in the cycle after the tick; data visible 1 cycle after ack.
  - Minimum tick-to-display latency is 2 cycles (when ack is in the first REQ cycle).
- Scan address advance: addr+1, wrapping to 0 when addr == depth-1.
  - After the wrap, the next displayed fetch is addr 0; there is no idle gap.
- Timeout: the counter increments each REQ cycle without ack. When it reaches TIMEOUT:
  - Drop rd_req_o.
  - disp_data_o=32'hFFFFFFFF, disp_addr_o=rd_addr_o, disp_valid_o=1.
  - Scan addr advances; state=IDLE.
- Late ack: rd_ack_i while in IDLE is ignored.
- Tick during REQ: sets pending (at most one pending tick; extra ticks are dropped).
  - A pending tick starts the next fetch in the first IDLE cycle.
- Source change (src_sel_i differs from latched src):
  - While in REQ: abort the request next cycle with no display update; scan addr=0, pending=0, state=IDLE, disp_valid_o=0.
  - While in IDLE: scan addr=0 and disp_valid_o=0 immediately.
  - The latched src updates on the next fetch start.
- Select 00 at any time: behaves as a source change, then stays IDLE; disp_data_o keeps its last value.
- Simultaneous tick and ack in REQ: the ack completes the current fetch and the tick becomes pending, so the next fetch starts one cycle later.
- All 6-bit address arithmetic is unsigned; depths up to 64 are supported.

Test Plan:
- RF sweep, single-cycle ack:
  - Stimulus: src=01; ack in the first REQ cycle with rd_data_i = 32'h100+addr; 33 ticks spaced 10 cycles apart.
  - Required: rd_addr_o sequence 0..31 then 0; disp_data_o 32'h100..32'h11F then 32'h100; each update lands 2 cycles after its tick.
- DM wrap with delayed ack:
  - Stimulus: src=10, DM_DEPTH=8, ack 3 cycles after request, 9 ticks.
  - Required: addresses 0..7 then 0; busy_o high exactly 4 cycles per fetch.
- Timeout:
  - Stimulus: src=11; rd_ack_i held at 0.
  - Required: rd_req_o high 15 cycles, then drops; disp_data_o=32'hFFFFFFFF and disp_valid_o=1; a late ack 2 cycles later changes nothing.
- Pending tick:
  - Stimulus: 3 ticks issued during one slow REQ.
  - Required: exactly one extra fetch; the next request starts in the cycle after the return to IDLE.
- Source switch mid-fetch:
  - Stimulus: RF fetch at addr 5 in REQ; src changes to DM.
  - Required: rd_req_o low next cycle; disp_valid_o=0; the next tick fetches DM addr 0 with rd_src_o=10.
- Async reset:
  - Stimulus: assert rstn=0 mid-REQ, between clock edges.
  - Required: rd_req_o and all outputs 0 immediately; after release, a tick fetches addr 0.
